// File: rtl/stage_mon_pkg.sv
// Shared encodings for the stage progress monitor: channel states, event kinds
// and the default start/pass stage codes.
package stage_mon_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RUN     = 3'd1,
        ST_PASS    = 3'd2,
        ST_FAIL    = 3'd3,
        ST_TIMEOUT = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        EVT_STAGE   = 2'd0,
        EVT_PASS    = 2'd1,
        EVT_FAIL    = 2'd2,
        EVT_TIMEOUT = 2'd3
    } evt_kind_e;

    localparam logic [7:0] DEF_START_CODE = 8'hFF;
    localparam logic [7:0] DEF_PASS_CODE  = 8'hFE;

endpackage

// File: rtl/stage_mon_channel.sv
// One monitored channel: input synchronizer, stability filter, progress FSM,
// timeout counter and single-entry event slot. STAGE_ORDER_CHECK_EN adds stage sequencing.
module stage_mon_channel
    import stage_mon_pkg::*;
#(
    parameter int                 STAGE_W    = 8,
    parameter int                 TMO_W      = 16,
    parameter logic [STAGE_W-1:0] START_CODE = DEF_START_CODE,
    parameter logic [STAGE_W-1:0] PASS_CODE  = DEF_PASS_CODE
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [STAGE_W-1:0] i_stage,
    input  logic               i_error,
    input  logic [TMO_W-1:0]   i_tmo_limit,
    input  logic               i_tick,
    input  logic               i_clear,
    input  logic               i_pop,
    output logic [2:0]         o_status,
    output logic               o_pend,
    output logic [1:0]         o_pend_kind,
    output logic [STAGE_W-1:0] o_pend_stage,
    output logic               o_ovf
);

    logic [STAGE_W-1:0] r_stage_p0, r_stage_p1, r_stage_p2, r_acc;
    logic               r_err_p0, r_err_p1;
    state_e             r_state, w_next;
    logic [TMO_W-1:0]   r_tmo;
    logic               r_pend;
    evt_kind_e          r_pkind, w_evt_kind;
    logic [STAGE_W-1:0] r_pstage, w_evt_stage;
    logic               w_stable, w_chg, w_tmo_hit, w_evt, w_tmo_rst;

    // p0/p1: two-flop synchronizer; p2: previous synchronized sample for the filter
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stage_p0 <= '0;
            r_stage_p1 <= '0;
            r_stage_p2 <= '0;
            r_err_p0   <= 1'b0;
            r_err_p1   <= 1'b0;
            r_acc      <= '0;
        end else begin
            r_stage_p0 <= i_stage;
            r_stage_p1 <= r_stage_p0;
            r_stage_p2 <= r_stage_p1;
            r_err_p0   <= i_error;
            r_err_p1   <= r_err_p0;
            if (w_stable) r_acc <= r_stage_p1;
        end
    end

    assign w_stable  = (r_stage_p1 == r_stage_p2);
    assign w_chg     = w_stable && (r_stage_p1 != r_acc);
    assign w_tmo_hit = (i_tmo_limit != '0) && (r_tmo >= i_tmo_limit);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= ST_IDLE;
        else          r_state <= w_next;
    end

    // Priority: clear, then error, then stage change, then timeout
    always_comb begin
        w_next      = r_state;
        w_evt       = 1'b0;
        w_evt_kind  = EVT_STAGE;
        w_evt_stage = r_stage_p1;
        w_tmo_rst   = 1'b0;
        if (i_clear) begin
            w_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_chg && (r_stage_p1 == START_CODE)) begin
                        w_next    = ST_RUN;
                        w_evt     = 1'b1;
                        w_tmo_rst = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (r_err_p1) begin
                        w_next      = ST_FAIL;
                        w_evt       = 1'b1;
                        w_evt_kind  = EVT_FAIL;
                        w_evt_stage = r_acc;
                    end else if (w_chg) begin
                        w_evt = 1'b1;
                        if (r_stage_p1 == PASS_CODE) begin
                            w_next     = ST_PASS;
                            w_evt_kind = EVT_PASS;
`ifdef STAGE_ORDER_CHECK_EN
                        end else if (r_stage_p1 != r_acc + 1'b1) begin
                            w_next     = ST_FAIL;
                            w_evt_kind = EVT_FAIL;
`endif
                        end else begin
                            w_tmo_rst = 1'b1;
                        end
                    end else if (w_tmo_hit) begin
                        w_next      = ST_TIMEOUT;
                        w_evt       = 1'b1;
                        w_evt_kind  = EVT_TIMEOUT;
                        w_evt_stage = r_acc;
                    end
                end
                default: ;
            endcase
        end
    end

    // Counter only runs in RUN and saturates at all-ones
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tmo <= '0;
        end else if (w_tmo_rst || (r_state != ST_RUN)) begin
            r_tmo <= '0;
        end else if (i_tick && (r_tmo != {TMO_W{1'b1}})) begin
            r_tmo <= r_tmo + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pend   <= 1'b0;
            r_pkind  <= EVT_STAGE;
            r_pstage <= '0;
        end else if (i_clear) begin
            r_pend <= 1'b0;
        end else if (w_evt) begin
            r_pend   <= 1'b1;
            r_pkind  <= w_evt_kind;
            r_pstage <= w_evt_stage;
        end else if (i_pop) begin
            r_pend <= 1'b0;
        end
    end

    assign o_ovf        = w_evt && r_pend && !i_pop;
    assign o_status     = r_state;
    assign o_pend       = r_pend;
    assign o_pend_kind  = r_pkind;
    assign o_pend_stage = r_pstage;

endmodule

// File: rtl/stage_progress_monitor.sv
// Multi-channel stage progress monitor: per-channel trackers, shared timeout prescaler,
// lowest-index event arbiter and valid/ready output register. Optional macro: STAGE_ORDER_CHECK_EN.
module stage_progress_monitor
    import stage_mon_pkg::*;
#(
    parameter int                 STAGE_W    = 8,
    parameter int                 CHANNELS   = 2,
    parameter int                 TMO_W      = 16,
    parameter int                 PRESC_W    = 8,
    parameter logic [STAGE_W-1:0] START_CODE = DEF_START_CODE,
    parameter logic [STAGE_W-1:0] PASS_CODE  = DEF_PASS_CODE
) (
    input  logic                        wb_clk_i,
    input  logic                        rst_n,
    input  logic [CHANNELS*STAGE_W-1:0] stage_i,
    input  logic [CHANNELS-1:0]         error_i,
    input  logic [TMO_W-1:0]            tmo_limit_i,
    input  logic [CHANNELS-1:0]         clear_i,
    output logic [CHANNELS*3-1:0]       status_o,
    output logic                        evt_valid_o,
    input  logic                        evt_ready_i,
    output logic [2:0]                  evt_chan_o,
    output logic [1:0]                  evt_kind_o,
    output logic [STAGE_W-1:0]          evt_stage_o,
    output logic                        overflow_o
);

    logic [PRESC_W-1:0]  r_presc;
    logic                w_tick;
    logic [CHANNELS-1:0] w_pend, w_pop, w_ovf;
    logic [1:0]          w_pkind  [CHANNELS];
    logic [STAGE_W-1:0]  w_pstage [CHANNELS];
    logic                w_any, w_load;
    logic [2:0]          w_sel;
    logic [1:0]          w_sel_kind;
    logic [STAGE_W-1:0]  w_sel_stage;
    logic                r_valid, r_ovf;
    logic [2:0]          r_chan;
    logic [1:0]          r_kind;
    logic [STAGE_W-1:0]  r_stage;

    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) r_presc <= '0;
        else        r_presc <= r_presc + 1'b1;
    end

    assign w_tick = &r_presc;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        stage_mon_channel #(
            .STAGE_W    (STAGE_W),
            .TMO_W      (TMO_W),
            .START_CODE (START_CODE),
            .PASS_CODE  (PASS_CODE)
        ) u_ch (
            .i_clk        (wb_clk_i),
            .i_rst_n      (rst_n),
            .i_stage      (stage_i[g*STAGE_W +: STAGE_W]),
            .i_error      (error_i[g]),
            .i_tmo_limit  (tmo_limit_i),
            .i_tick       (w_tick),
            .i_clear      (clear_i[g]),
            .i_pop        (w_pop[g]),
            .o_status     (status_o[g*3 +: 3]),
            .o_pend       (w_pend[g]),
            .o_pend_kind  (w_pkind[g]),
            .o_pend_stage (w_pstage[g]),
            .o_ovf        (w_ovf[g])
        );
    end

    assign w_load = !r_valid || evt_ready_i;

    // Descending scan so the lowest pending index is the one left selected
    always_comb begin
        w_any       = 1'b0;
        w_sel       = '0;
        w_sel_kind  = '0;
        w_sel_stage = '0;
        w_pop       = '0;
        for (int c = CHANNELS - 1; c >= 0; c--) begin
            if (w_pend[c]) begin
                w_any       = 1'b1;
                w_sel       = 3'(c);
                w_sel_kind  = w_pkind[c];
                w_sel_stage = w_pstage[c];
            end
        end
        for (int c = 0; c < CHANNELS; c++) begin
            w_pop[c] = w_load && w_any && (w_sel == 3'(c));
        end
    end

    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_chan  <= '0;
            r_kind  <= '0;
            r_stage <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_load) begin
                r_valid <= w_any;
                if (w_any) begin
                    r_chan  <= w_sel;
                    r_kind  <= w_sel_kind;
                    r_stage <= w_sel_stage;
                end
            end
            if (|w_ovf) r_ovf <= 1'b1;
        end
    end

    assign evt_valid_o = r_valid;
    assign evt_chan_o  = r_chan;
    assign evt_kind_o  = r_kind;
    assign evt_stage_o = r_stage;
    assign overflow_o  = r_ovf;

endmodule

// File: tb/tb_stage_progress_monitor.sv
// Directed bench for stage_progress_monitor (2 channels, 2-bit prescaler); honours STAGE_ORDER_CHECK_EN.
module tb_stage_progress_monitor;

    localparam int STAGE_W  = 8;
    localparam int CHANNELS = 2;
    localparam int TMO_W    = 16;
    localparam int PRESC_W  = 2;

    logic                        clk = 1'b0;
    logic                        rst_n;
    logic [CHANNELS*STAGE_W-1:0] stage_i;
    logic [CHANNELS-1:0]         error_i;
    logic [TMO_W-1:0]            tmo_limit_i;
    logic [CHANNELS-1:0]         clear_i;
    logic [CHANNELS*3-1:0]       status_o;
    logic                        evt_valid_o;
    logic                        evt_ready_i;
    logic [2:0]                  evt_chan_o;
    logic [1:0]                  evt_kind_o;
    logic [STAGE_W-1:0]          evt_stage_o;
    logic                        overflow_o;

    int          checks = 0;
    int          errors = 0;
    logic [12:0] q[$];

    stage_progress_monitor #(
        .STAGE_W (STAGE_W), .CHANNELS (CHANNELS), .TMO_W (TMO_W), .PRESC_W (PRESC_W)
    ) dut (
        .wb_clk_i    (clk),
        .rst_n       (rst_n),
        .stage_i     (stage_i),
        .error_i     (error_i),
        .tmo_limit_i (tmo_limit_i),
        .clear_i     (clear_i),
        .status_o    (status_o),
        .evt_valid_o (evt_valid_o),
        .evt_ready_i (evt_ready_i),
        .evt_chan_o  (evt_chan_o),
        .evt_kind_o  (evt_kind_o),
        .evt_stage_o (evt_stage_o),
        .overflow_o  (overflow_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && evt_valid_o && evt_ready_i)
            q.push_back({evt_chan_o, evt_kind_o, evt_stage_o});
    end

    function automatic logic [12:0] ev(int c, int k, logic [7:0] s);
        return {3'(c), 2'(k), s};
    endfunction

    task automatic cyc(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_stg(int c, logic [7:0] v);
        stage_i[c*8 +: 8] = v;
    endtask

    task automatic wait_q(int n, int budget);
        for (int i = 0; i < budget && q.size() < n; i++) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; stage_i = '0; error_i = '0; clear_i = '0;
        tmo_limit_i = '0; evt_ready_i = 1'b0;
        #23;
        checks++; if (status_o !== 6'd0) begin errors++; $display("FAIL reset_status got %h want 00", status_o); end
        checks++; if (evt_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", evt_valid_o); end
        checks++; if ({evt_chan_o, evt_kind_o, evt_stage_o} !== 13'd0) begin
            errors++; $display("FAIL reset_evt got %h want 0000", {evt_chan_o, evt_kind_o, evt_stage_o}); end
        checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", overflow_o); end
        @(negedge clk); rst_n = 1'b1;
        cyc(3);
        checks++; if (evt_valid_o !== 1'b0) begin errors++; $display("FAIL post_reset_valid got %b want 0", evt_valid_o); end
    endtask

    task automatic test_pass_flow;
        logic [12:0] exp[4];
        logic [12:0] got;
        exp[0] = ev(0, 0, 8'hFF); exp[1] = ev(0, 0, 8'h00);
        exp[2] = ev(0, 0, 8'h01); exp[3] = ev(0, 1, 8'hFE);
        q.delete(); evt_ready_i = 1'b1;
        set_stg(0, 8'hFF); cyc(8);
        set_stg(0, 8'h00); cyc(8);
        set_stg(0, 8'h01); cyc(8);
        set_stg(0, 8'hFE); cyc(8);
        wait_q(4, 20);
        checks++; if (q.size() != 4) begin errors++; $display("FAIL pass_count got %0d want 4", q.size()); end
        for (int i = 0; i < 4; i++) begin
            got = (i < q.size()) ? q[i] : 13'h1FFF;
            checks++; if (got !== exp[i]) begin errors++; $display("FAIL pass_evt%0d got %h want %h", i, got, exp[i]); end
        end
        checks++; if (status_o[2:0] !== 3'd2) begin errors++; $display("FAIL pass_status got %0d want 2", status_o[2:0]); end
        clear_i = 2'b01; cyc(1); clear_i = '0;
        @(negedge clk);
        checks++; if (status_o[2:0] !== 3'd0) begin errors++; $display("FAIL clear_pass got %0d want 0", status_o[2:0]); end
    endtask

    task automatic test_fail;
        logic [12:0] exp[3];
        logic [12:0] got;
        exp[0] = ev(1, 0, 8'hFF); exp[1] = ev(1, 0, 8'h03); exp[2] = ev(1, 2, 8'h03);
        q.delete();
        set_stg(1, 8'hFF); cyc(8);
        set_stg(1, 8'h03); cyc(8);
        error_i[1] = 1'b1; cyc(8);
        wait_q(3, 20);
        for (int i = 0; i < 3; i++) begin
            got = (i < q.size()) ? q[i] : 13'h1FFF;
            checks++; if (got !== exp[i]) begin errors++; $display("FAIL fail_evt%0d got %h want %h", i, got, exp[i]); end
        end
        checks++; if (status_o[5:3] !== 3'd3) begin errors++; $display("FAIL fail_status got %0d want 3", status_o[5:3]); end
        error_i[1] = 1'b0; set_stg(1, 8'h04); cyc(12);
        checks++; if (q.size() != 3) begin errors++; $display("FAIL fail_terminal_count got %0d want 3", q.size()); end
        checks++; if (status_o[5:3] !== 3'd3) begin errors++; $display("FAIL fail_sticky got %0d want 3", status_o[5:3]); end
        clear_i = 2'b10; cyc(1); clear_i = '0; cyc(1);
        checks++; if (status_o[5:3] !== 3'd0) begin errors++; $display("FAIL clear_fail got %0d want 0", status_o[5:3]); end
    endtask

    task automatic test_timeout;
        logic [12:0] got;
        q.delete(); tmo_limit_i = 16'd3;
        set_stg(0, 8'hFF); cyc(8);
        set_stg(0, 8'h05); cyc(8);
        checks++; if (q.size() != 2) begin errors++; $display("FAIL tmo_early got %0d events want 2", q.size()); end
        wait_q(3, 40);
        got = (q.size() > 2) ? q[2] : 13'h1FFF;
        checks++; if (got !== ev(0, 3, 8'h05)) begin errors++; $display("FAIL tmo_evt got %h want %h", got, ev(0, 3, 8'h05)); end
        checks++; if (status_o[2:0] !== 3'd4) begin errors++; $display("FAIL tmo_status got %0d want 4", status_o[2:0]); end
        tmo_limit_i = '0;
        clear_i = 2'b01; cyc(1); clear_i = '0; cyc(2);
        q.delete();
        set_stg(0, 8'hFF); cyc(100);
        got = (q.size() > 0) ? q[0] : 13'h1FFF;
        checks++; if (q.size() != 1) begin errors++; $display("FAIL tmo_dis_count got %0d want 1", q.size()); end
        checks++; if (got !== ev(0, 0, 8'hFF)) begin errors++; $display("FAIL tmo_dis_evt got %h want %h", got, ev(0, 0, 8'hFF)); end
        checks++; if (status_o[2:0] !== 3'd1) begin errors++; $display("FAIL tmo_dis_status got %0d want 1", status_o[2:0]); end
        clear_i = 2'b01; cyc(1); clear_i = '0; cyc(2);
    endtask

    task automatic test_back_to_back;
        logic [12:0] exp[3];
        logic [12:0] got;
        exp[0] = ev(0, 0, 8'hFF); exp[1] = ev(0, 0, 8'h01); exp[2] = ev(1, 0, 8'hFF);
        set_stg(0, 8'h00); set_stg(1, 8'h00); cyc(8);
        q.delete(); evt_ready_i = 1'b0;
        set_stg(0, 8'hFF); set_stg(1, 8'hFF); cyc(8);
        @(negedge clk);
        checks++; if ({evt_valid_o, evt_chan_o, evt_kind_o, evt_stage_o} !== {1'b1, ev(0, 0, 8'hFF)}) begin
            errors++; $display("FAIL stall_first got %h want %h", {evt_valid_o, evt_chan_o, evt_kind_o, evt_stage_o}, {1'b1, ev(0, 0, 8'hFF)}); end
        cyc(1); set_stg(0, 8'h00); cyc(8);
        checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL ovf_premature got %b want 0", overflow_o); end
        set_stg(0, 8'h01); cyc(8);
        @(negedge clk);
        checks++; if ({evt_valid_o, evt_chan_o, evt_kind_o, evt_stage_o} !== {1'b1, ev(0, 0, 8'hFF)}) begin
            errors++; $display("FAIL stall_hold got %h want %h", {evt_valid_o, evt_chan_o, evt_kind_o, evt_stage_o}, {1'b1, ev(0, 0, 8'hFF)}); end
        checks++; if (overflow_o !== 1'b1) begin errors++; $display("FAIL ovf_set got %b want 1", overflow_o); end
        checks++; if (q.size() != 0) begin errors++; $display("FAIL stall_leak got %0d want 0", q.size()); end
        @(posedge clk); #1 evt_ready_i = 1'b1;
        repeat (3) begin @(negedge clk); #1; end
        checks++; if (q.size() != 3) begin errors++; $display("FAIL no_bubble got %0d want 3", q.size()); end
        for (int i = 0; i < 3; i++) begin
            got = (i < q.size()) ? q[i] : 13'h1FFF;
            checks++; if (got !== exp[i]) begin errors++; $display("FAIL drain_evt%0d got %h want %h", i, got, exp[i]); end
        end
        @(negedge clk);
        checks++; if (evt_valid_o !== 1'b0) begin errors++; $display("FAIL drain_idle got %b want 0", evt_valid_o); end
    endtask

    task automatic test_glitch_clear;
        logic [12:0] got;
        q.delete();
        set_stg(0, 8'h55); cyc(1); set_stg(0, 8'h01); cyc(10);
        checks++; if (q.size() != 0) begin errors++; $display("FAIL glitch got %0d events want 0", q.size()); end
        checks++; if (status_o[2:0] !== 3'd1) begin errors++; $display("FAIL glitch_status got %0d want 1", status_o[2:0]); end
        evt_ready_i = 1'b0;
        set_stg(1, 8'h00); cyc(8);
        set_stg(0, 8'h02); cyc(8);
        clear_i = 2'b01; cyc(1); clear_i = '0; cyc(1);
        checks++; if (status_o[2:0] !== 3'd0) begin errors++; $display("FAIL clear_run got %0d want 0", status_o[2:0]); end
        evt_ready_i = 1'b1; cyc(10);
        got = (q.size() > 0) ? q[0] : 13'h1FFF;
        checks++; if (q.size() != 1) begin errors++; $display("FAIL clear_drop got %0d events want 1", q.size()); end
        checks++; if (got !== ev(1, 0, 8'h00)) begin errors++; $display("FAIL clear_keep got %h want %h", got, ev(1, 0, 8'h00)); end
    endtask

    task automatic test_reset_mid;
        evt_ready_i = 1'b0; q.delete();
        set_stg(1, 8'h01); cyc(8);
        @(negedge clk);
        checks++; if (evt_valid_o !== 1'b1) begin errors++; $display("FAIL mid_pre_valid got %b want 1", evt_valid_o); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (evt_valid_o !== 1'b0) begin errors++; $display("FAIL mid_valid got %b want 0", evt_valid_o); end
        checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL mid_ovf got %b want 0", overflow_o); end
        checks++; if (status_o !== 6'd0) begin errors++; $display("FAIL mid_status got %h want 00", status_o); end
        @(negedge clk); rst_n = 1'b1;
        cyc(6);
        checks++; if (evt_valid_o !== 1'b0) begin errors++; $display("FAIL mid_after got %b want 0", evt_valid_o); end
    endtask

    task automatic test_order;
        logic [12:0] exp[3];
        logic [2:0]  exp_st;
        logic [12:0] got;
        exp[0] = ev(0, 0, 8'hFF); exp[1] = ev(0, 0, 8'h00);
`ifdef STAGE_ORDER_CHECK_EN
        exp[2] = ev(0, 2, 8'h02); exp_st = 3'd3;
`else
        exp[2] = ev(0, 0, 8'h02); exp_st = 3'd1;
`endif
        evt_ready_i = 1'b1; q.delete();
        set_stg(0, 8'hFF); cyc(8);
        set_stg(0, 8'h00); cyc(8);
        set_stg(0, 8'h02); cyc(8);
        wait_q(3, 20);
        for (int i = 0; i < 3; i++) begin
            got = (i < q.size()) ? q[i] : 13'h1FFF;
            checks++; if (got !== exp[i]) begin errors++; $display("FAIL order_evt%0d got %h want %h", i, got, exp[i]); end
        end
        checks++; if (status_o[2:0] !== exp_st) begin errors++; $display("FAIL order_status got %0d want %0d", status_o[2:0], exp_st); end
    endtask

    initial begin
        test_reset();
        test_pass_flow();
        test_fail();
        test_timeout();
        test_back_to_back();
        test_glitch_clear();
        test_reset_mid();
        test_order();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
